// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard sequencer.
// The datapath side uses the master modport; the sequencer uses the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned RA_W = 5
);
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [RA_W-1:0] ex_rd;
  logic            ex_mem_rd;
  logic            ex_br_taken;
  logic            mem_req;
  logic            mem_ready;
  logic            hlt_MEM;
  logic            hlt_WB;

  logic            pc_en;
  logic            if_id_en;
  logic            id_ex_en;
  logic            ex_mem_en;
  logic            mem_wb_en;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            ex_mem_flush;
  logic            mem_wb_flush;
  logic            halted;
  logic            mem_err;

  modport master (
    output id_rs, id_rt, ex_rd, ex_mem_rd, ex_br_taken, mem_req, mem_ready, hlt_MEM, hlt_WB,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted, mem_err
  );

  modport slave (
    input  id_rs, id_rt, ex_rd, ex_mem_rd, ex_br_taken, mem_req, mem_ready, hlt_MEM, hlt_WB,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: drives buffer enables/flushes and pc_en from load-use, branch,
// data-memory wait and hlt drain conditions.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned RA_W        = 5
) (
  input logic                   clk,
  input logic                   reset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RA_W-1:0] RegZero = '0;

  typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            ret_drain_q, ret_drain_d;
  logic            halted_q;
  logic            mem_err_q, mem_err_d;

  logic load_use;
  logic stall, run_eval, drain_eval, freeze;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

  assign load_use = hz.ex_mem_rd && (hz.ex_rd != RegZero) &&
                    ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    ret_drain_d  = ret_drain_q;
    mem_err_d    = mem_err_q;
    stall        = 1'b0;
    run_eval     = 1'b0;
    drain_eval   = 1'b0;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;

    unique case (state_q)
      StRun: begin
        if (hz.mem_req && !hz.mem_ready) begin
          stall       = 1'b1;
          state_d     = StMemWait;
          wait_cnt_d  = CntW'(1);
          ret_drain_d = 1'b0;
        end else begin
          run_eval = 1'b1;
        end
      end
      StDrain: begin
        if (hz.mem_req && !hz.mem_ready) begin
          stall       = 1'b1;
          state_d     = StMemWait;
          wait_cnt_d  = CntW'(1);
          ret_drain_d = 1'b1;
        end else begin
          drain_eval = 1'b1;
        end
      end
      StMemWait: begin
        if (!hz.mem_ready) begin
          stall = 1'b1;
          if (wait_cnt_q == CntW'(MEM_TIMEOUT)) begin
            state_d    = StHalted;
            mem_err_d  = 1'b1;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
          end
        end else begin
          // Completion cycle: resume whichever context the stall interrupted.
          wait_cnt_d  = '0;
          ret_drain_d = 1'b0;
          if (ret_drain_q) drain_eval = 1'b1;
          else             run_eval   = 1'b1;
        end
      end
      StHalted: begin
        freeze     = 1'b1;
        wait_cnt_d = '0;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end

    if (drain_eval) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = hz.hlt_WB ? StHalted : StDrain;
    end

    if (run_eval) begin
      state_d = StRun;
      if (hz.hlt_MEM) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = StDrain;
      end else if (hz.ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    // Reset and halt both freeze every buffer with no bubbles injected.
    if (freeze || !reset_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      ret_drain_q <= 1'b0;
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ret_drain_q <= ret_drain_d;
      halted_q    <= (state_d == StHalted);
      mem_err_q   <= mem_err_d;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_en    = mem_wb_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.halted       = halted_q;
  assign hz.mem_err      = mem_err_q;

endmodule
